// File: rtl/ft245_pkg.sv
// Shared types and default strobe timing for the FT245 parallel FIFO link.
package ft245_pkg;

  localparam int unsigned RD_LOW_CYC_DEF  = 7;
  localparam int unsigned RD_HIGH_CYC_DEF = 3;
  localparam int unsigned WR_HIGH_CYC_DEF = 7;
  localparam int unsigned WR_LOW_CYC_DEF  = 6;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned TMR_W  = 8;
  localparam int unsigned WCNT_W = 7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_LOW,
    S_RD_HIGH,
    S_TX_FETCH,
    S_TX_SET,
    S_TX_PULSE,
    S_TX_HOLD,
    S_DONE
  } ft245_state_e;

endpackage

// File: rtl/ft245_link_if.sv
// FT245 bus pins plus the command/burst side-band, as seen by the link (master) and its environment (slave).
interface ft245_link_if;
  import ft245_pkg::*;

  logic              RXF;
  logic              TXE;
  logic [BYTE_W-1:0] USB_DIN;
  logic [BYTE_W-1:0] USB_DOUT;
  logic              USB_OE;
  logic              RD;
  logic              WR;
  logic              cmd_valid;
  logic [BYTE_W-1:0] cmd_byte;
  logic              tx_start;
  logic [BYTE_W-1:0] tx_len;
  logic              word_req;
  logic              word_ack;
  logic [WORD_W-1:0] word_data;
  logic              busy;
  logic              tx_done;

  modport master (
    input  RXF, TXE, USB_DIN, tx_start, tx_len, word_ack, word_data,
    output USB_DOUT, USB_OE, RD, WR, cmd_valid, cmd_byte, word_req, busy, tx_done
  );

  modport slave (
    output RXF, TXE, USB_DIN, tx_start, tx_len, word_ack, word_data,
    input  USB_DOUT, USB_OE, RD, WR, cmd_valid, cmd_byte, word_req, busy, tx_done
  );

endinterface

// File: rtl/ft245_cyc_timer.sv
// Loadable down-counter; the zero flag marks the last cycle of a strobe phase.
module ft245_cyc_timer
  import ft245_pkg::*;
#(
  parameter int unsigned W = TMR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero_c
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/ft245_link.sv
// FT245 link: services host command reads and streams 16-bit memory words out as byte bursts.
module ft245_link
  import ft245_pkg::*;
#(
  parameter int unsigned RD_LOW_CYC  = RD_LOW_CYC_DEF,
  parameter int unsigned RD_HIGH_CYC = RD_HIGH_CYC_DEF,
  parameter int unsigned WR_HIGH_CYC = WR_HIGH_CYC_DEF,
  parameter int unsigned WR_LOW_CYC  = WR_LOW_CYC_DEF
) (
  input  logic         CLK,
  input  logic         RSTN,
  ft245_link_if.master bus
);

  // Timer is loaded with N-1 so a phase lasts exactly N cycles including the load cycle's successor.
  localparam logic [TMR_W-1:0] RD_LOW_LD  = TMR_W'(RD_LOW_CYC - 1);
  localparam logic [TMR_W-1:0] RD_HIGH_LD = TMR_W'(RD_HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] WR_HIGH_LD = TMR_W'(WR_HIGH_CYC - 1);
  localparam logic [TMR_W-1:0] WR_LOW_LD  = TMR_W'(WR_LOW_CYC - 1);

  ft245_state_e      r_state;
  logic              r_rd;
  logic              r_wr;
  logic              r_oe;
  logic [BYTE_W-1:0] r_dout;
  logic [BYTE_W-1:0] r_cmd_byte;
  logic              r_cmd_valid;
  logic              r_word_req;
  logic              r_busy;
  logic              r_tx_done;
  logic              r_byte_sel;
  logic [BYTE_W-1:0] r_hi_byte;
  logic [WCNT_W-1:0] r_words;

  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_zero;
  logic              w_unused;

  // Odd burst lengths are rounded down, so the length LSB carries no information.
  assign w_unused = bus.tx_len[0];

  // Phase timer reloads on every transition into a timed strobe phase.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    case (r_state)
      S_IDLE: begin
        if (!bus.RXF) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = RD_LOW_LD;
        end
      end
      S_RD_LOW: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = RD_HIGH_LD;
        end
      end
      S_TX_SET: begin
        if (!bus.TXE) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = WR_HIGH_LD;
        end
      end
      S_TX_PULSE: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          w_tmr_val  = WR_LOW_LD;
        end
      end
      default: ;
    endcase
  end

  ft245_cyc_timer #(.W(TMR_W)) u_timer (
    .clk      (CLK),
    .rst_n    (RSTN),
    .i_load   (w_tmr_load),
    .i_val    (w_tmr_val),
    .o_zero_c (w_tmr_zero)
  );

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= S_IDLE;
      r_rd        <= 1'b1;
      r_wr        <= 1'b0;
      r_oe        <= 1'b0;
      r_dout      <= '0;
      r_cmd_byte  <= '0;
      r_cmd_valid <= 1'b0;
      r_word_req  <= 1'b0;
      r_busy      <= 1'b0;
      r_tx_done   <= 1'b0;
      r_byte_sel  <= 1'b0;
      r_hi_byte   <= '0;
      r_words     <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_tx_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A pending receive always wins over a burst request in the same cycle.
          if (!bus.RXF) begin
            r_rd    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_RD_LOW;
          end else if (bus.tx_start) begin
            r_busy <= 1'b1;
            if (bus.tx_len[BYTE_W-1:1] == '0) begin
              r_tx_done <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_words    <= bus.tx_len[BYTE_W-1:1];
              r_word_req <= 1'b1;
              r_state    <= S_TX_FETCH;
            end
          end
        end
        S_RD_LOW: begin
          if (w_tmr_zero) begin
            r_cmd_byte  <= bus.USB_DIN;
            r_cmd_valid <= 1'b1;
            r_rd        <= 1'b1;
            r_state     <= S_RD_HIGH;
          end
        end
        S_RD_HIGH: begin
          if (w_tmr_zero) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_TX_FETCH: begin
          if (bus.word_ack) begin
            r_hi_byte  <= bus.word_data[WORD_W-1:BYTE_W];
            r_dout     <= bus.word_data[BYTE_W-1:0];
            r_byte_sel <= 1'b0;
            r_word_req <= 1'b0;
            r_oe       <= 1'b1;
            r_state    <= S_TX_SET;
          end
        end
        S_TX_SET: begin
          if (!bus.TXE) begin
            r_wr    <= 1'b1;
            r_state <= S_TX_PULSE;
          end
        end
        S_TX_PULSE: begin
          if (w_tmr_zero) begin
            r_wr    <= 1'b0;
            r_state <= S_TX_HOLD;
          end
        end
        S_TX_HOLD: begin
          if (w_tmr_zero) begin
            if (!r_byte_sel) begin
              r_byte_sel <= 1'b1;
              r_dout     <= r_hi_byte;
              r_state    <= S_TX_SET;
            end else begin
              r_words <= r_words - WCNT_W'(1);
              r_oe    <= 1'b0;
              if (r_words == WCNT_W'(1)) begin
                r_tx_done <= 1'b1;
                r_state   <= S_DONE;
              end else begin
                r_word_req <= 1'b1;
                r_state    <= S_TX_FETCH;
              end
            end
          end
        end
        S_DONE: begin
          r_oe    <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.RD        = r_rd;
  assign bus.WR        = r_wr;
  assign bus.USB_OE    = r_oe;
  assign bus.USB_DOUT  = r_dout;
  assign bus.cmd_byte  = r_cmd_byte;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.word_req  = r_word_req;
  assign bus.busy      = r_busy;
  assign bus.tx_done   = r_tx_done;

endmodule

// File: doc/ft245_link.md
FT245_LINK -- requirements
Module: ft245_link

Interface
REQ-001 SHALL have parameter RD_LOW_CYC, default 7, meaning RD low duration in CLK cycles (56 ns at 125 MHz).
REQ-002 SHALL have parameter RD_HIGH_CYC, default 3, meaning RD recovery high time before the next read.
REQ-003 SHALL have parameter WR_HIGH_CYC, default 7, meaning WR high pulse width per byte.
REQ-004 SHALL have parameter WR_LOW_CYC, default 6, meaning WR low / data hold time after each byte.
REQ-005 SHALL have one clock; reset is asynchronous and active-low (ports CLK and RSTN).
REQ-006 CLK  in  1  125 MHz system clock.
REQ-007 RSTN  in  1  asynchronous active-low reset.
REQ-008 RXF  in  1  FT245 receive FIFO not-empty, active low.
REQ-009 TXE  in  1  FT245 transmit FIFO has space, active low.
REQ-010 USB_DIN  in  8  sampled USB data bus.
REQ-011 USB_DOUT  out  8  byte driven onto the USB bus.
REQ-012 USB_OE  out  1  tristate enable for USB_DOUT.
REQ-013 RD  out  1  FT245 read strobe, idle 1, active low.
REQ-014 WR  out  1  FT245 write strobe, idle 0, byte latched on falling edge.
REQ-015 cmd_valid  out  1  one-cycle pulse, new command byte.
REQ-016 cmd_byte  out  8  last received command, held until the next one.
REQ-017 tx_start  in  1  pulse; starts a burst of tx_len bytes.
REQ-018 tx_len  in  8  burst length in bytes, sampled with tx_start.
REQ-019 word_req  out  1  request for the next 16-bit memory word.
REQ-020 word_ack  in  1  word_data valid this cycle.
REQ-021 word_data  in  16  memory word, low byte sent first.
REQ-022 busy  out  1  high in any state other than IDLE.
REQ-023 tx_done  out  1  one-cycle pulse at burst end.

Function
REQ-024 FSM states: IDLE, RD_LOW, RD_HIGH, TX_FETCH, TX_SET, TX_PULSE, TX_HOLD, DONE.
REQ-025 IDLE: RXF=0 -> RD_LOW; tx_start takes effect only when RXF=1 (receive has priority).
REQ-026 RD_LOW: RD=0 for RD_LOW_CYC cycles; USB_DIN latched into cmd_byte in the last cycle, with cmd_valid pulsed that cycle; then -> RD_HIGH.
REQ-027 RD_HIGH: RD=1 for RD_HIGH_CYC cycles, then -> IDLE; RXF is ignored during this state.
REQ-028 tx_start with tx_len[7:1]=0: tx_done is pulsed the next cycle and no WR edge occurs; tx_len[0] is ignored (burst rounded down to an even length).
REQ-029 Valid tx_start: remaining-word counter = tx_len/2 -> TX_FETCH.
REQ-030 TX_FETCH: word_req held high until word_ack; word_data is latched and byte select = low -> TX_SET.
REQ-031 TX_SET: USB_OE=1, USB_DOUT = selected byte; waits while TXE=1; with TXE=0 -> TX_PULSE the next cycle.
REQ-032 TX_PULSE: WR=1 for WR_HIGH_CYC cycles -> TX_HOLD.
REQ-033 TX_HOLD: WR=0 with USB_DOUT stable for WR_LOW_CYC cycles.
REQ-034 TX_HOLD exit for the low byte: -> TX_SET with the high byte.
REQ-035 TX_HOLD exit for the high byte: decrement the word counter; if nonzero -> TX_FETCH, else -> DONE.
REQ-036 DONE: tx_done pulse, USB_OE=0 -> IDLE.
REQ-037 USB_OE SHALL never be 1 while RD=0; USB_OE is 1 only in TX_SET, TX_PULSE and TX_HOLD.
REQ-038 tx_start while busy=1 is ignored; RXF is not serviced during a burst.
REQ-039 Maximum burst is 127 words (254 bytes); the word counter does not wrap.

Reset
REQ-040 Async RSTN=0 forces state IDLE, RD=1, WR=0, USB_OE=0, USB_DOUT=0, cmd_byte=0, cmd_valid=0, word_req=0, tx_done=0, busy=0 and all counters to 0, including mid-strobe; a burst interrupted by reset is discarded.

Structure
REQ-041 Package ft245_pkg SHALL hold the state enumeration and the default timing constants.
REQ-042 Sub-module ft245_cyc_timer SHALL be a loadable down-counter with a zero flag, shared by the RD and WR phases.

Verification
REQ-043 RXF=0, USB_DIN=0x07 -> RD low for exactly 7 cycles, cmd_byte=0x07, one cmd_valid pulse, RD high for 3 cycles minimum before the next read.
REQ-044 tx_start, tx_len=4, word_data 0x1234 then 0xABCD, TXE=0 -> WR falling edges with USB_DOUT sequence 0x34, 0x12, 0xCD, 0xAB; two word_req handshakes; one tx_done.
REQ-045 TXE=1 for 20 cycles after first TX_SET -> WR stays 0 and USB_DOUT is held; burst resumes correctly once TXE=0.
REQ-046 tx_len=0 and tx_len=1 -> tx_done next cycle, no WR activity, no word_req.
REQ-047 RXF=0 and tx_start in the same IDLE cycle -> read performed and tx_start dropped; RSTN low mid-TX_PULSE -> WR=0 and USB_OE=0 immediately.
REQ-048 Assertion across all tests: USB_OE and RD=0 are never high/low simultaneously; word_req is never high outside TX_FETCH.
